// File: rtl/aes_pkg.sv
// Shared types and S-box tables for the AES SubBytes engine.
// Optional feature macro: SBOX_INV_EN adds the inverse S-box table.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_LAST   = 2'd2,
    ST_HOLD   = 2'd3
  } eng_state_e;

  localparam byte_t SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SBOX_INV_EN
  localparam byte_t SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_lane.sv
// One S-box lane: synchronous ROM read with a single registered output,
// structured so synthesis can map it onto block RAM (no reset on the data flop).
// Optional feature macro: SBOX_INV_EN adds the inv select and inverse table.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
`ifdef SBOX_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] data
);

  byte_t data_q;
  byte_t data_d;

  // Table read for the address presented this cycle.
  always_comb begin
`ifdef SBOX_INV_EN
    if (inv) begin
      data_d = SBOX_INV[addr];
    end else begin
      data_d = SBOX_FWD[addr];
    end
`else
    data_d = SBOX_FWD[addr];
`endif
  end

  // Output register giving the lane its one-cycle read latency.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/aes_subbytes_engine.sv
// AES SubBytes engine: captures a 128-bit state, pushes it through LANES
// S-box lanes over BEATS = 16/LANES beats and holds the result until taken.
// Optional feature macro: SBOX_INV_EN adds the inv port (inverse S-box).
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef SBOX_INV_EN
  input  logic         inv,
`endif
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  eng_state_e      state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [BW-1:0]   rb_q, rb_d;         // beat whose lookup result is on the lanes now
  logic            rv_q, rv_d;         // lanes hold a result to write back
  state_t          cap_q, cap_d;
  state_t          out_q, out_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;
`ifdef SBOX_INV_EN
  logic            inv_q, inv_d;
`endif

  logic [0:15][7:0] cap_bytes_s;       // index 0 is the most significant byte
  byte_t            lane_addr_s [LANES];
  byte_t            lane_data_s [LANES];

  assign cap_bytes_s = cap_q;

  // Control FSM: capture on accept, step beats, then hold the result for the consumer.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = ST_LOOKUP;
          beat_d  = {BW{1'b0}};
          cap_d   = in_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (beat_q == BW'(BEATS - 1)) begin
          state_d = ST_LAST;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_LAST: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = {BW{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

`ifdef SBOX_INV_EN
  // Direction select is latched with the state so it stays fixed for the whole operation.
  always_comb begin
    if (state_q == ST_IDLE && in_valid && in_ready_q) begin
      inv_d = inv;
    end else begin
      inv_d = inv_q;
    end
  end
`endif

  // Lane addressing: beat k feeds bytes k*LANES .. k*LANES+LANES-1.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_addr_s[l] = cap_bytes_s[4'(int'(beat_q) * LANES + l)];
    end
  end

  // Write-back: the lanes answer one cycle after a beat is presented.
  always_comb begin
    logic [0:15][7:0] ob;
    ob   = out_q;
    rv_d = (state_q == ST_LOOKUP);
    rb_d = beat_q;
    if (rv_q) begin
      for (int l = 0; l < LANES; l++) begin
        ob[4'(int'(rb_q) * LANES + l)] = lane_data_s[l];
      end
    end else begin
      ob = out_q;
    end
    out_d = ob;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .clk  (clk),
      .addr (lane_addr_s[g]),
`ifdef SBOX_INV_EN
      .inv  (inv_q),
`endif
      .data (lane_data_s[g])
    );
  end

  // State, counters, captured input and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= {BW{1'b0}};
      rb_q        <= {BW{1'b0}};
      rv_q        <= 1'b0;
      cap_q       <= 128'h0;
      out_q       <= 128'h0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rb_q        <= rb_d;
      rv_q        <= rv_d;
      cap_q       <= cap_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SBOX_INV_EN
  // Captured direction select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: doc/aes_subbytes_engine.md
AES_SUBBYTES_ENGINE -- requirements
Module: aes_subbytes_engine

Interface
REQ-001 Parameter LANES, default 4: number of parallel S-box lookups per beat; legal values 1, 2, 4, 8, 16.
REQ-002 Derived localparam BEATS = 16/LANES: lookup beats per 128-bit state.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  engine can accept a new state.
REQ-007 in_data  input  128  state to substitute; byte 0 = [127:120], byte 15 = [7:0].
REQ-008 out_valid  output  1  out_data holds a completed result.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  128  substituted state, same byte order as in_data.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 inv  input  1  selects inverse S-box; port exists only when SBOX_INV_EN is defined.

Function
REQ-013 The FSM SHALL have states IDLE, LOOKUP, LAST, HOLD.
REQ-014 in_ready SHALL be high only in IDLE; a transfer occurs on in_valid && in_ready at a rising edge.
REQ-015 On transfer, the engine SHALL register in_data (and inv) and the beat counter SHALL clear to 0; IDLE -> LOOKUP.
REQ-016 In LOOKUP, beat k SHALL present bytes k*LANES .. k*LANES+LANES-1 to the lanes, then increment k; when k = BEATS-1 is presented, LOOKUP -> LAST.
REQ-017 Each lane SHALL have exactly one clock of read latency; the result of beat k SHALL be written into the byte positions of out_data on the edge after beat k+1 is presented, or on the LAST edge for the final beat.
REQ-018 LAST -> HOLD unconditionally; out_valid SHALL rise exactly BEATS+1 cycles after the accepting edge (LANES=16: 2 cycles; LANES=1: 17 cycles).
REQ-019 In HOLD, out_valid SHALL be high and out_data stable until out_valid && out_ready; the engine then returns to IDLE. No new input is accepted in the cycle of the output handshake.
REQ-020 out_data SHALL hold its last value after the output handshake until the next result overwrites it.
REQ-021 in_valid asserted outside IDLE SHALL be ignored, with no side effects.
REQ-022 out_ready asserted outside HOLD SHALL be ignored.
REQ-023 Beat counter width SHALL be max(1,$clog2(BEATS)); it SHALL never exceed BEATS-1.
REQ-024 An illegal LANES value SHALL raise an elaboration-time $error.

Reset
REQ-025 When reset_n is low: state = IDLE, beat counter = 0, out_valid = 0, busy = 0, out_data = 0, captured state = 0; in_ready SHALL be 1 once reset_n is high.
REQ-026 Reset asserted mid-operation (LOOKUP, LAST, HOLD) SHALL abort the operation immediately; no partial result is ever flagged valid.

Configuration
REQ-027 With SBOX_INV_EN defined: port inv exists; inv captured at transfer selects the inverse S-box for the whole operation.
REQ-028 Without SBOX_INV_EN: no inv port, no inverse table, forward S-box only; latency is unchanged.

Structure
REQ-029 Package aes_pkg SHALL hold the state typedef (128-bit), the byte typedef, the forward S-box table and the inverse S-box table (inverse table under SBOX_INV_EN).
REQ-030 Sub-module aes_sbox_lane (one per lane, generate loop) SHALL implement a synchronous ROM lookup (8-bit address, optional inv select, registered 8-bit output) inferable as block RAM.

Verification
REQ-031 LANES=4: in_data = 193DE3BEA0F4E22B9AC68D2AE9F84808 -> out_data = D42711AEE0BF98F1B8B45DE51E415230, out_valid rises 5 cycles after the accept.
REQ-032 LANES=16 and LANES=1: in_data = all 00 -> out_data = all 63, with 2-cycle and 17-cycle latency respectively.
REQ-033 Back-pressure: hold out_ready = 0 for 10 cycles after out_valid and pulse in_valid during that window -> out_data stable, in_ready stays 0, the second input is not taken; out_ready = 1 -> IDLE the next cycle.
REQ-034 Reset pulse on the 2nd LOOKUP cycle (LANES=4) -> out_valid never asserts, busy = 0 and out_data = 0 during reset; a following FIPS transfer completes correctly.
REQ-035 SBOX_INV_EN, inv=1: in_data = D42711AEE0BF98F1B8B45DE51E415230 -> out_data = 193DE3BEA0F4E22B9AC68D2AE9F84808; inv=1 with all 63 -> all 00.
